// File: rtl/ram_bus_master.sv
// Bus-side initiator for the 256x8 main memory: one request at a time, registered
// strobes, and tri-state write data on the shared bus.
`timescale 1ns/1ps
module ram_bus_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int RD_WAIT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_sa,
    output logic              mem_s,
    output logic              mem_e,
    inout  wire  [DATA_W-1:0] bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WSTB, S_WHOLD, S_RSTB, S_DONE
    } state_t;

    localparam logic [3:0] LP_RD_WAIT = 4'(RD_WAIT);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [3:0]          r_wait_cnt;
    logic [3:0]          w_wait_cnt_nxt;
    logic                w_accept;
    logic                w_rd_last;
    logic                w_bus_drive;
    logic                w_ready_nxt;
    logic                w_valid_nxt;
    logic                w_sa_nxt;
    logic                w_s_nxt;
    logic                w_e_nxt;

    assign w_accept  = req_valid && req_ready;
    assign w_rd_last = (r_wait_cnt == LP_RD_WAIT);

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_ADDR;
            S_ADDR: begin
                w_state_nxt    = r_we ? S_WSTB : S_RSTB;
                w_wait_cnt_nxt = 4'd0;
            end
            S_WSTB:  w_state_nxt = S_WHOLD;
            S_WHOLD: w_state_nxt = S_DONE;
            S_RSTB: begin
                if (w_rd_last) w_state_nxt = S_DONE;
                else           w_wait_cnt_nxt = r_wait_cnt + 4'd1;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        // Outputs are registered, so they are decoded from the state being entered.
        w_ready_nxt = (w_state_nxt == S_IDLE);
        w_sa_nxt    = (w_state_nxt == S_ADDR);
        w_s_nxt     = (w_state_nxt == S_WSTB);
        w_e_nxt     = (w_state_nxt == S_RSTB);
        w_valid_nxt = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 4'd0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            mem_a      <= '0;
            mem_sa     <= 1'b0;
            mem_s      <= 1'b0;
            mem_e      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            req_ready  <= w_ready_nxt;
            rsp_valid  <= w_valid_nxt;
            mem_sa     <= w_sa_nxt;
            mem_s      <= w_s_nxt;
            mem_e      <= w_e_nxt;
            if (w_accept)
                mem_a <= req_addr;
            if ((r_state == S_RSTB) && w_rd_last)
                rsp_rdata <= bus;
        end
    end

    // Request payload is data only; it is consumed after the handshake and needs no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= req_we;
            r_wdata <= req_wdata;
        end
    end

    assign w_bus_drive = (r_state == S_WSTB) || (r_state == S_WHOLD);
    assign bus         = w_bus_drive ? r_wdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: two instances (RD_WAIT 0 and 2), each with a behavioural
// RAM on its own bus, driven from a vector table, corner-case sequences and random traffic.
`timescale 1ns/1ps
module tb_ram_bus_master;
    localparam logic [7:0] PROBE = 8'h5A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [1:0]      rv, rwe, rdy, vld, sa, st, oe;
    logic [1:0][7:0] raddr, rwd, rdat, ma;
    wire  [7:0]      bus0, bus1;

    logic [7:0]      ram [2][256];
    logic [1:0][7:0] areg;
    logic [1:0]      probe;
    logic            init;
    logic [7:0]      ref_mem [2][256];
    logic [7:0]      last_rd [2];

    typedef struct {
        int         k;
        logic       we;
        logic [7:0] addr;
        logic [7:0] exp;
        int         lat;
        int         acc;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    ram_bus_master #(.ADDR_W(8), .DATA_W(8), .RD_WAIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_ready(rdy[0]),
        .req_we(rwe[0]), .req_addr(raddr[0]), .req_wdata(rwd[0]),
        .rsp_valid(vld[0]), .rsp_rdata(rdat[0]), .mem_a(ma[0]),
        .mem_sa(sa[0]), .mem_s(st[0]), .mem_e(oe[0]), .bus(bus0)
    );

    ram_bus_master #(.ADDR_W(8), .DATA_W(8), .RD_WAIT(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_ready(rdy[1]),
        .req_we(rwe[1]), .req_addr(raddr[1]), .req_wdata(rwd[1]),
        .rsp_valid(vld[1]), .rsp_rdata(rdat[1]), .mem_a(ma[1]),
        .mem_sa(sa[1]), .mem_s(st[1]), .mem_e(oe[1]), .bus(bus1)
    );

    function automatic logic [7:0] busv(input int k);
        return (k == 0) ? bus0 : bus1;
    endfunction

    // Behavioural memory: address register loaded on sa, level-sensitive store on s.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (init) begin
                areg[k] <= 8'h00;
                for (int i = 0; i < 256; i++) ram[k][i] <= 8'(i * 7 + 3);
            end else begin
                if (sa[k]) areg[k] <= ma[k];
                if (st[k]) ram[k][areg[k]] <= busv(k);
            end
        end
    end

    assign bus0 = oe[0] ? ram[0][areg[0]] : (probe[0] ? PROBE : 8'hzz);
    assign bus1 = oe[1] ? ram[1][areg[1]] : (probe[1] ? PROBE : 8'hzz);

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        exp_t x;
        @(negedge clk);
        cyc++;
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("s_with_e", 32'(st[k] & oe[k]), 32'd0);
                chk("sa_overlap", 32'(sa[k] & (st[k] | oe[k])), 32'd0);
                if (oe[k]) chk("bus_contention", 32'(busv(k)), 32'(ram[k][areg[k]]));
                if (vld[k]) begin
                    if (sbq.size() == 0) begin
                        chk("spurious_rsp", 32'(vld[k]), 32'd0);
                    end else begin
                        x = sbq.pop_front();
                        chk("rsp_dut", 32'(k), 32'(x.k));
                        chk("rsp_rdata", 32'(rdat[k]), 32'(x.exp));
                        chk("rsp_latency", 32'(cyc - x.acc), 32'(x.lat));
                    end
                end
            end
        end
    endtask

    task automatic chk_released(input int k, input string name);
        probe[k] = 1'b1;
        #1;
        chk(name, 32'(busv(k)), 32'(PROBE));
        probe[k] = 1'b0;
    endtask

    task automatic chk_idle(input int k);
        chk("idle_sa", 32'(sa[k]), 32'd0);
        chk("idle_s", 32'(st[k]), 32'd0);
        chk("idle_e", 32'(oe[k]), 32'd0);
        chk("idle_ready", 32'(rdy[k]), 32'd1);
        chk("idle_rsp_valid", 32'(vld[k]), 32'd0);
        chk_released(k, "idle_bus_z");
    endtask

    task automatic run_req(input int k, input logic we, input logic [7:0] a,
                           input logic [7:0] d, input bit churn);
        int   t     = 0;
        int   s_cnt = 0;
        int   e_cnt = 0;
        int   lat;
        exp_t x;
        rwe[k] = we; raddr[k] = a; rwd[k] = d; rv[k] = 1'b1;
        while (!rdy[k] && t < 20) begin
            tick();
            t++;
        end
        chk("accept_ready", 32'(rdy[k]), 32'd1);
        if (!rdy[k]) begin
            rv[k] = 1'b0;
            return;
        end
        lat   = we ? 4 : 3 + ((k == 0) ? 0 : 2);
        x.k   = k;
        x.we  = we;
        x.addr = a;
        x.exp = we ? last_rd[k] : ref_mem[k][a];
        x.lat = lat;
        x.acc = cyc;
        sbq.push_back(x);
        if (we) ref_mem[k][a] = d;
        else    last_rd[k] = ref_mem[k][a];
        @(posedge clk);
        #1;
        if (!churn) rv[k] = 1'b0;
        for (int n = 1; n <= lat + 4; n++) begin
            tick();
            if (n <= lat) begin
                chk("mem_a_hold", 32'(ma[k]), 32'(a));
                chk("ready_busy", 32'(rdy[k]), 32'd0);
            end
            if (st[k]) begin
                s_cnt++;
                chk("write_bus", 32'(busv(k)), 32'(d));
            end
            if (oe[k]) e_cnt++;
            if (churn) begin
                raddr[k] = 8'($urandom);
                rwd[k]   = 8'($urandom);
                rwe[k]   = ~rwe[k];
            end
            if (sbq.size() == 0) break;
        end
        rv[k] = 1'b0;
        chk("rsp_timeout", 32'(sbq.size()), 32'd0);
        sbq.delete();
        chk("mem_s_cycles", 32'(s_cnt), we ? 32'd1 : 32'd0);
        chk("mem_e_cycles", 32'(e_cnt), we ? 32'd0 : 32'(lat - 2));
        chk_released(k, "done_bus_z");
    endtask

    initial begin
        vec_t tbl [8];
        int   t;
        int   mism;

        tbl[0] = '{1'b1, 8'h3C, 8'hA5, 8'h00};
        tbl[1] = '{1'b0, 8'h3C, 8'h00, 8'hA5};
        tbl[2] = '{1'b1, 8'h00, 8'h11, 8'hA5};
        tbl[3] = '{1'b1, 8'hFF, 8'hEE, 8'hA5};
        tbl[4] = '{1'b0, 8'h00, 8'h00, 8'h11};
        tbl[5] = '{1'b0, 8'hFF, 8'h00, 8'hEE};
        tbl[6] = '{1'b1, 8'h3C, 8'h77, 8'hEE};
        tbl[7] = '{1'b0, 8'h3C, 8'h00, 8'h77};

        rst_n = 1'b0;
        init  = 1'b1;
        probe = 2'b00;
        for (int k = 0; k < 2; k++) begin
            rv[k] = 1'b1; rwe[k] = 1'b1; raddr[k] = 8'h81; rwd[k] = 8'hC3;
            last_rd[k] = 8'h00;
            for (int i = 0; i < 256; i++) ref_mem[k][i] = 8'(i * 7 + 3);
        end

        // Reset held two cycles with a request pending.
        repeat (2) begin
            @(posedge clk);
            tick();
            for (int k = 0; k < 2; k++) begin
                chk_idle(k);
                chk("reset_mem_a", 32'(ma[k]), 32'd0);
                chk("reset_rdata", 32'(rdat[k]), 32'd0);
            end
        end
        init  = 1'b0;
        rst_n = 1'b1;
        rv    = 2'b00;
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("no_accept_ready", 32'(rdy[k]), 32'd1);
            chk("no_accept_sa", 32'(sa[k]), 32'd0);
        end
        chk_en = 1'b1;

        // Vector table, including write 3C=A5 then read back.
        for (int i = 0; i < 8; i++) begin
            run_req(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, 1'b0);
            chk("vec_rdata", 32'(rdat[0]), 32'(tbl[i].exp));
        end

        // RD_WAIT = 2 read at the top address.
        run_req(1, 1'b1, 8'hFF, 8'h5A, 1'b0);
        run_req(1, 1'b0, 8'hFF, 8'h00, 1'b0);
        chk("rdwait_rdata", 32'(rdat[1]), 32'h5A);

        // Request inputs churn every cycle after acceptance.
        run_req(0, 1'b1, 8'h96, 8'h3B, 1'b1);
        run_req(0, 1'b0, 8'h96, 8'h00, 1'b1);
        chk("churn_rdata", 32'(rdat[0]), 32'h3B);

        // Reset while the write strobe is up.
        rwe[0] = 1'b1; raddr[0] = 8'h42; rwd[0] = 8'hA5; rv[0] = 1'b1;
        t = 0;
        while (!rdy[0] && t < 20) begin
            tick();
            t++;
        end
        chk("abort_accept", 32'(rdy[0]), 32'd1);
        @(posedge clk);
        #1;
        rv[0] = 1'b0;
        ref_mem[0][8'h42] = 8'hA5;
        tick();
        chk("abort_addr_phase", 32'(sa[0]), 32'd1);
        tick();
        chk("abort_wstb", 32'(st[0]), 32'd1);
        chk("abort_wstb_bus", 32'(bus0), 32'hA5);
        rst_n = 1'b0;
        tick();
        chk_idle(0);
        chk("abort_rdata", 32'(rdat[0]), 32'd0);
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            chk("abort_no_rsp", 32'(vld[0]), 32'd0);
        end
        mism = 0;
        for (int i = 0; i < 256; i++) if (ram[0][i] !== ref_mem[0][i]) mism++;
        chk("abort_ram_contents", 32'(mism), 32'd0);

        // Random traffic, mostly on the zero-wait instance.
        for (int i = 0; i < 500; i++) begin
            run_req((i % 10 == 9) ? 1 : 0, 1'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
